// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES encrypt/decrypt core, one Feistel round per clock.
// Contains IP/FP, E, S1-S8, P and the PC-1/rotate/PC-2 key schedule.
// Define DES_KEY_PARITY_EN to enable per-byte odd-parity checking of the key (key_err).
module des_round_engine #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic        busy,
    output logic        done,
    output logic        key_err
);

    localparam logic [4:0] CNT_LAST = 5'(ROUNDS);

    // Tables use FIPS numbering: entry value 1 refers to the MSB of the source vector.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    // S1..S8, each 4 rows x 16 columns, indexed {box, row, column}.
    localparam logic [3:0] S_TAB [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,

        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,

        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,

         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,

         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,

        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,

         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,

        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
    };

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
        return y;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
        return y;
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
        return y;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
        return y;
    endfunction

    function automatic logic [47:0] f_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[5'(32 - E_T[k])];
        return y;
    endfunction

    function automatic logic [31:0] f_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) y[5'(31 - k)] = x[5'(32 - P_T[k])];
        return y;
    endfunction

    // Each 6-bit group b1..b6: row = b1b6, column = b2..b5; S1 takes the upper group.
    function automatic logic [31:0] f_sbox(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        y = '0;
        for (int s = 0; s < 8; s++) begin
            six = x[47 - 6 * s -: 6];
            y[31 - 4 * s -: 4] = S_TAB[{3'(s), six[5], six[0], six[4:1]}];
        end
        return y;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
    function automatic logic f_one_shift(input logic [4:0] i);
        return (i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
    endfunction

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_dec;
    logic [63:0] r_dout;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_one;
    logic [27:0] w_c_next;
    logic [27:0] w_d_next;
    logic [47:0] w_k;
    logic [31:0] w_f;
    logic [31:0] w_l_new;
    logic [31:0] w_r_new;

    assign w_accept = (r_state == StIdle) && start;

    // Single-cycle round: key schedule step, subkey selection and Feistel function.
    always_comb begin
        w_one = r_dec ? f_one_shift(5'd17 - r_cnt) : f_one_shift(r_cnt);
        if (r_dec) begin
            // Decrypt uses the current C,D for its subkey, then rotates right.
            w_c_next = w_one ? {r_c[0], r_c[27:1]} : {r_c[1:0], r_c[27:2]};
            w_d_next = w_one ? {r_d[0], r_d[27:1]} : {r_d[1:0], r_d[27:2]};
            w_k      = f_pc2({r_c, r_d});
        end else begin
            w_c_next = w_one ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
            w_d_next = w_one ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};
            w_k      = f_pc2({w_c_next, w_d_next});
        end
        w_f     = f_p(f_sbox(f_e(r_r) ^ w_k));
        w_l_new = r_r;
        w_r_new = r_l ^ w_f;
    end

    // Control FSM and datapath registers: load on start, iterate, emit result after last round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_l     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_dec   <= 1'b0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        {r_l, r_r} <= f_ip(din);
                        {r_c, r_d} <= f_pc1(key);
                        r_dec      <= decrypt;
                        r_cnt      <= 5'd1;
                        r_busy     <= 1'b1;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    r_l <= w_l_new;
                    r_r <= w_r_new;
                    r_c <= w_c_next;
                    r_d <= w_d_next;
                    if (r_cnt == CNT_LAST) begin
                        // Halves are swapped before the final permutation.
                        r_dout  <= f_fp({w_r_new, w_l_new});
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;

`ifdef DES_KEY_PARITY_EN
    // A key byte with an even number of ones violates DES odd parity.
    function automatic logic f_parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) bad = bad | ~(^k[8 * b +: 8]);
        return bad;
    endfunction

    logic r_key_err;

    // Parity flag is captured with the key and held until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_err <= 1'b0;
        end else if (w_accept) begin
            r_key_err <= f_parity_bad(key);
        end
    end

    assign key_err = r_key_err;
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine using known-answer DES vectors.
// Honours DES_KEY_PARITY_EN for the expected key_err value.
`timescale 1ns/1ps
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key = '0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic        busy;
    logic        done;
    logic        key_err;

    int total = 0;
    int bad = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] C0 = 64'h8CA64DE9C1B123A7;

`ifdef DES_KEY_PARITY_EN
    localparam logic ZERO_KEY_ERR = 1'b1;
`else
    localparam logic ZERO_KEY_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    des_round_engine #(.ROUNDS(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .decrypt (decrypt),
        .key     (key),
        .din     (din),
        .dout    (dout),
        .busy    (busy),
        .done    (done),
        .key_err (key_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic pulse_start(input logic dec, input logic [63:0] k, input logic [63:0] d);
        decrypt = dec;
        key     = k;
        din     = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        decrypt = ~dec;
        key     = ~k;
        din     = ~d;
    endtask

    // Counts cycles from the start edge to done; flags any dout change before done.
    task automatic wait_done(input bit poke, output int lat, output bit changed);
        logic [63:0] prev;
        prev    = dout;
        changed = 1'b0;
        lat     = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (poke && lat == 5) begin
                start = 1'b1;
                din   = 64'h0F0F0F0F0F0F0F0F;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (done !== 1'b1 && dout !== prev) changed = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic dec, input logic [63:0] k,
                             input logic [63:0] d, input logic [63:0] exp, input bit poke);
        int lat;
        bit changed;
        @(negedge clk);
        pulse_start(dec, k, d);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        wait_done(poke, lat, changed);
        chk({tag, "_latency"}, 64'(lat), 64'd16);
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_hold"}, {63'd0, changed}, 64'd0);
    endtask

    initial begin
        int lat;
        int cnt;
        bit changed;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", dout, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_key_err", {63'd0, key_err}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Known-answer encrypt.
        run_check("enc1", 1'b0, K1, P1, C1, 1'b0);
        chk("enc1_key_err", {63'd0, key_err}, 64'd0);
        @(negedge clk);
        chk("enc1_done_pulse", {63'd0, done}, 64'd0);
        chk("enc1_idle", {63'd0, busy}, 64'd0);
        chk("enc1_dout_held", dout, C1);

        // Inverse of the same vector.
        run_check("dec1", 1'b1, K1, C1, P1, 1'b0);

        // Start pulsed mid-operation must be ignored.
        run_check("enc2", 1'b0, K2, P2, 64'd0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("enc2_no_extra_done", 64'(cnt), 64'd0);
        chk("enc2_dout_after", dout, 64'd0);

        // Zero key (even parity in every byte), then a back-to-back start on the done cycle.
        run_check("enc0", 1'b0, 64'd0, 64'd0, C0, 1'b0);
        chk("enc0_key_err", {63'd0, key_err}, {63'd0, ZERO_KEY_ERR});
        pulse_start(1'b1, K1, C1);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_first_held", dout, C0);
        wait_done(1'b0, lat, changed);
        chk("b2b_latency", 64'(lat), 64'd16);
        chk("b2b_dout", dout, P1);
        chk("b2b_hold", {63'd0, changed}, 64'd0);
        chk("b2b_key_err", {63'd0, key_err}, 64'd0);

        // Reset in the middle of a block aborts it.
        @(negedge clk);
        pulse_start(1'b0, K1, P1);
        repeat (7) @(negedge clk);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_dout", dout, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'd0);
        chk("abort_dout_still_zero", dout, 64'd0);

        // Fresh block after the aborted one.
        run_check("enc1_again", 1'b0, K1, P1, C1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
Iterative single-block DES encrypt/decrypt core computing one Feistel round per clock. It contains the full datapath:
- initial permutation (IP), final permutation (FP)
- expansion E (32→48), subkey XOR, S-boxes S1–S8, permutation P
- key schedule: PC-1, per-half rotations, PC-2

It sits between a block-level controller that supplies key/plaintext with a start strobe and the consumer of the 64-bit result.

Parameters:
- ROUNDS, 16, number of Feistel rounds executed. Only 16 is a supported value; it exists for verification reach.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to process one block; sampled only when idle.
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with start.
- key  in  64  DES key including parity bits; sampled with start.
- din  in  64  input block; sampled with start.
- dout  out  64  result block; holds its value until the next completion.
- busy  out  1  high while rounds are in progress.
- done  out  1  one-cycle pulse when dout is updated.
- key_err  out  1  key parity flag (see Optional Feature).

Behaviour:
- Bit numbering: the FIPS 46-3 tables use bit 1 = MSB. For 64-bit vectors, bit 1 = [63]; for 32-bit vectors, bit 1 = [31]. All permutation and expansion tables are exactly those of FIPS 46-3.
- Reset (rst_n=0, asynchronous): dout=0, busy=0, done=0, key_err=0, round counter=0, L/R/C/D registers=0.
- Idle (busy=0) with start=1 on a clock edge:
  - {L,R} ← IP(din), with L = upper 32 bits.
  - {C,D} ← PC1(key), 28 bits each.
  - Latch the mode bit; counter ← 1; busy ← 1.
- Shift schedule v(i), for i = 1..16: 1 for i ∈ {1, 2, 9, 16}, 2 otherwise. Rotations act on C and D independently.
- Each busy cycle runs round i = counter:
  - Encrypt: C,D ← rotl(C,D by v(i)); K = PC2(rotated C,D).
  - Decrypt: K = PC2(current C,D); then C,D ← rotr(C,D by v(17−i)).
  - f = P(S(E(R) XOR K)). S-box i takes 6 bits b1..b6: row = b1b6, column = b2..b5. S1 consumes the upper 6 bits.
  - L ← R; R ← L XOR f; counter ← counter+1.
- After round 16 (the edge where counter=16):
  - dout ← FP({R_new, L_new}), i.e. halves swapped before FP.
  - done ← 1 for exactly one cycle; busy ← 0; counter ← 0.
- Latency: if start is sampled at edge N, done=1 and dout is valid after edge N+16. The next start can be accepted on the edge where done is high.
- start while busy: ignored; inputs are not resampled.
- key, din and decrypt may change freely after the start edge.
- Reset asserted mid-operation: the block is aborted, all outputs return to reset values, and no done is issued.
- done never asserts without a preceding accepted start.
- The combinational round function must be a single-cycle path.

Optional Feature:
Macro DES_KEY_PARITY_EN.
- Defined: on the start edge, key_err ← 1 if any key byte has even parity (odd parity is required per byte). key_err holds until the next accepted start or reset. Encryption proceeds regardless of key_err.
- Undefined: key_err is tied to 0 and no parity logic is generated.

Test Plan:
- Encrypt, key=133457799BBCDFF1, din=0123456789ABCDEF → done 16 cycles after start, dout=85E813540F0AB405, key_err=0.
- Decrypt, key=133457799BBCDFF1, din=85E813540F0AB405 → dout=0123456789ABCDEF.
- Encrypt, key=0E329232EA6D0D73, din=8787878787878787 → dout=0000000000000000. Pulse start again while busy: no extra done, result unchanged.
- Encrypt, key=0000000000000000, din=0000000000000000 → dout=8CA64DE9C1B123A7. With DES_KEY_PARITY_EN: key_err=1; without it: key_err=0.
- Assert rst_n=0 at round 8 → dout=0, busy=0, done stays 0. A new start after release gives the correct result.
- Back-to-back: start on the done cycle with a new block → the second result follows 16 cycles later. The first dout holds until then.
